jk_bank_controller: RTL and testbench

JK_BANK_CONTROLLER -- requirements
Module: jk_bank_controller

---
 rtl/jk_bank_controller.sv | 189 ++++++++++++++++++
 tb/tb_jk_bank_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_controller.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank_controller
// Description : Command sequencer for an external bank of four positive-edge
//               JK flip-flops. A request selects one of HOLD/CLEAR/SET/TOGGLE/
//               LOAD. The command is applied for CNT+1 clock edges under a
//               per-bit mask. A shadow copy of the expected bank contents is
//               kept, and the bank outputs are compared against it on
//               completion.
// Ports       : i_clk    - system clock, shared with the JK bank
//               i_rst    - asynchronous active-high reset
//               i_req    - command request, sampled only in IDLE
//               i_op     - command code (000..100 legal, 101..111 illegal)
//               i_mask   - per-bit enable
//               i_data   - LOAD value
//               i_cnt    - repeat count (command applied CNT+1 edges)
//               i_q      - Q outputs of the external JK bank
//               o_j/o_k  - registered J/K drive to the bank
//               o_busy   - high in every state other than IDLE
//               o_ack    - one-cycle completion pulse
//               o_err    - result flag, valid with o_ack, held until next ACK
//               o_shadow - expected bank contents
// Revision    : 1.0 - initial release
// ============================================================================
module jk_bank_controller (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req,
    input  logic [2:0] i_op,
    input  logic [3:0] i_mask,
    input  logic [3:0] i_data,
    input  logic [3:0] i_cnt,
    input  logic [3:0] i_q,
    output logic [3:0] o_j,
    output logic [3:0] o_k,
    output logic       o_busy,
    output logic       o_ack,
    output logic       o_err,
    output logic [3:0] o_shadow
);

    localparam logic [2:0] c_OP_HOLD   = 3'b000;
    localparam logic [2:0] c_OP_CLEAR  = 3'b001;
    localparam logic [2:0] c_OP_SET    = 3'b010;
    localparam logic [2:0] c_OP_TOGGLE = 3'b011;
    localparam logic [2:0] c_OP_LOAD   = 3'b100;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_DRIVE = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t     r_state;
    logic       r_init_done;   // first post-reset edge has been spent in INIT
    logic [3:0] r_rem;         // DRIVE edges remaining after the current one
    logic       r_illegal;     // latched command had an illegal opcode
    logic [3:0] r_j;
    logic [3:0] r_k;
    logic       r_busy;
    logic       r_ack;
    logic       r_err;
    logic [3:0] r_shadow;

    logic [3:0] w_j_enc;
    logic [3:0] w_k_enc;
    logic       w_illegal;
    logic [3:0] w_shadow_next;

    // Per-bit J/K encoding of the incoming command, gated by the mask.
    always_comb begin
        w_j_enc   = 4'b0000;
        w_k_enc   = 4'b0000;
        w_illegal = 1'b0;
        case (i_op)
            c_OP_HOLD: begin
                w_j_enc = 4'b0000;
                w_k_enc = 4'b0000;
            end
            c_OP_CLEAR: begin
                w_j_enc = 4'b0000;
                w_k_enc = i_mask;
            end
            c_OP_SET: begin
                w_j_enc = i_mask;
                w_k_enc = 4'b0000;
            end
            c_OP_TOGGLE: begin
                w_j_enc = i_mask;
                w_k_enc = i_mask;
            end
            c_OP_LOAD: begin
                w_j_enc = i_data & i_mask;
                w_k_enc = ~i_data & i_mask;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // JK characteristic equation applied bitwise: Q+ = J&~Q | ~K&Q.
    assign w_shadow_next = (r_j & ~r_shadow) | (~r_k & r_shadow);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_INIT;
            r_init_done <= 1'b0;
            r_rem       <= 4'd0;
            r_illegal   <= 1'b0;
            r_j         <= 4'b0000;
            r_k         <= 4'b1111;
            r_busy      <= 1'b1;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_shadow    <= 4'b0000;
        end else begin
            case (r_state)
                ST_INIT: begin
                    // Hold K high for one full post-reset edge so the bank is
                    // guaranteed cleared before accepting commands.
                    if (!r_init_done) begin
                        r_init_done <= 1'b1;
                        r_j         <= 4'b0000;
                        r_k         <= 4'b1111;
                    end else begin
                        r_j     <= 4'b0000;
                        r_k     <= 4'b0000;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    r_ack <= 1'b0;
                    r_j   <= 4'b0000;
                    r_k   <= 4'b0000;
                    if (i_req) begin
                        r_j       <= w_j_enc;
                        r_k       <= w_k_enc;
                        r_rem     <= i_cnt;
                        r_illegal <= w_illegal;
                        r_busy    <= 1'b1;
                        r_state   <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    // The bank captures the current J/K at this edge; mirror it.
                    r_shadow <= w_shadow_next;
                    if (r_rem == 4'd0) begin
                        r_j     <= 4'b0000;
                        r_k     <= 4'b0000;
                        r_state <= ST_CHECK;
                    end else begin
                        r_rem <= r_rem - 4'd1;
                    end
                end
                ST_CHECK: begin
                    r_err   <= (i_q != r_shadow) | r_illegal;
                    r_ack   <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_INIT;
                    r_init_done <= 1'b0;
                    r_j         <= 4'b0000;
                    r_k         <= 4'b1111;
                    r_busy      <= 1'b1;
                    r_ack       <= 1'b0;
                end
            endcase
        end
    end

    assign o_j      = r_j;
    assign o_k      = r_k;
    assign o_busy   = r_busy;
    assign o_ack    = r_ack;
    assign o_err    = r_err;
    assign o_shadow = r_shadow;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_bank_controller
// Description : Self-checking bench for jk_bank_controller. Models the external
//               JK flip-flop bank, applies a table of directed commands and a
//               few hand-written reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_bank_controller;

    logic       clk;
    logic       rst;
    logic       req;
    logic [2:0] op;
    logic [3:0] mask;
    logic [3:0] data;
    logic [3:0] cnt;
    logic [3:0] q;
    logic [3:0] j;
    logic [3:0] k;
    logic       busy;
    logic       ack;
    logic       err;
    logic [3:0] shadow;

    logic [3:0] bank;
    logic [3:0] flip;

    int total = 0;
    int bad   = 0;

    jk_bank_controller dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_req    (req),
        .i_op     (op),
        .i_mask   (mask),
        .i_data   (data),
        .i_cnt    (cnt),
        .i_q      (q),
        .o_j      (j),
        .o_k      (k),
        .o_busy   (busy),
        .o_ack    (ack),
        .o_err    (err),
        .o_shadow (shadow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External JK bank model.
    initial bank = 4'b0101;
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            case ({j[b], k[b]})
                2'b00: bank[b] <= bank[b];
                2'b01: bank[b] <= 1'b0;
                2'b10: bank[b] <= 1'b1;
                2'b11: bank[b] <= ~bank[b];
                default: bank[b] <= 1'bx;
            endcase
        end
    end

    // flip lets the bench present a corrupted Q to the controller.
    assign q = bank ^ flip;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0] op;
        logic [3:0] mask;
        logic [3:0] data;
        logic [3:0] cnt;
        logic [3:0] ej;
        logic [3:0] ek;
        logic [3:0] eq;
        logic       eerr;
        logic       flipq;
        logic       pulse;
    } vec_t;

    vec_t vecs[9];

    task automatic run_cmd(input vec_t v);
        int lat;
        @(negedge clk);
        op   = v.op;
        mask = v.mask;
        data = v.data;
        cnt  = v.cnt;
        req  = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        chk("jdrive", j, v.ej);
        chk("kdrive", k, v.ek);
        chk("busy_start", busy, 1'b1);
        lat = 0;
        while (!ack && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            // Requests while busy must be ignored.
            if (v.pulse) req = (lat < 5) ? lat[0] : 1'b0;
            if (lat == int'(v.cnt) + 1) begin
                chk("jk_off", {j, k}, 8'h00);
                if (v.flipq) flip = 4'b0001;
            end
        end
        req  = 1'b0;
        flip = 4'b0000;
        chk("latency", lat, int'(v.cnt) + 2);
        chk("err", err, v.eerr);
        chk("bank_q", bank, v.eq);
        chk("shadow", shadow, v.eq);
        @(posedge clk);
        #1;
        chk("ack_fall", ack, 1'b0);
        chk("busy_fall", busy, 1'b0);
        chk("err_hold", err, v.eerr);
    endtask

    initial begin
        //          op      mask     data     cnt    ej       ek       eq     err flip pulse
        vecs[0] = '{3'b010, 4'b1010, 4'b0000, 4'd0,  4'b1010, 4'b0000, 4'b1010, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{3'b011, 4'b0011, 4'b0000, 4'd2,  4'b0011, 4'b0011, 4'b1001, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{3'b100, 4'b1111, 4'b0110, 4'd15, 4'b0110, 4'b1001, 4'b0110, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{3'b111, 4'b1111, 4'b1111, 4'd1,  4'b0000, 4'b0000, 4'b0110, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{3'b011, 4'b0000, 4'b0000, 4'd3,  4'b0000, 4'b0000, 4'b0110, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{3'b011, 4'b1100, 4'b0000, 4'd3,  4'b1100, 4'b1100, 4'b0110, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{3'b001, 4'b0100, 4'b0000, 4'd0,  4'b0000, 4'b0100, 4'b0010, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{3'b100, 4'b0101, 4'b1111, 4'd4,  4'b0101, 4'b0000, 4'b0111, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{3'b000, 4'b1111, 4'b0000, 4'd0,  4'b0000, 4'b0000, 4'b0111, 1'b1, 1'b1, 1'b0};

        rst  = 1'b1;
        req  = 1'b0;
        op   = 3'b000;
        mask = 4'b0000;
        data = 4'b0000;
        cnt  = 4'd0;
        flip = 4'b0000;

        // Reset state, with the bank clocked while K is held high.
        #1;
        chk("rst_j", j, 4'b0000);
        chk("rst_k", k, 4'b1111);
        chk("rst_busy", busy, 1'b1);
        chk("rst_ack", ack, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_shadow", shadow, 4'b0000);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("init1_k", k, 4'b1111);
        chk("init1_busy", busy, 1'b1);
        @(posedge clk);
        #1;
        chk("idle_busy", busy, 1'b0);
        chk("idle_jk", {j, k}, 8'h00);
        chk("idle_q", bank, 4'b0000);
        chk("idle_shadow", shadow, 4'b0000);

        // Idle with REQ low ignores command inputs.
        op   = 3'b010;
        mask = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_noreq_busy", busy, 1'b0);
        chk("idle_noreq_j", j, 4'b0000);

        for (int i = 0; i < 9; i++) run_cmd(vecs[i]);

        // Reset in the middle of a long TOGGLE: no ACK, bank cleared.
        @(negedge clk);
        op   = 3'b011;
        mask = 4'b1111;
        cnt  = 4'd8;
        req  = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        chk("mid_j", j, 4'b1111);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 1'b1);
        chk("mid_rst_k", k, 4'b1111);
        chk("mid_rst_ack", ack, 1'b0);
        chk("mid_rst_shadow", shadow, 4'b0000);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_init_busy", busy, 1'b1);
        chk("mid_init_k", k, 4'b1111);
        chk("mid_init_ack", ack, 1'b0);
        @(posedge clk);
        #1;
        chk("mid_idle_busy", busy, 1'b0);
        chk("mid_idle_ack", ack, 1'b0);
        chk("mid_idle_q", bank, 4'b0000);
        chk("mid_idle_shadow", shadow, 4'b0000);

        // Normal operation resumes after the abort.
        run_cmd('{3'b010, 4'b0001, 4'b0000, 4'd1, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
